// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit multiplexed seven-segment driver with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 20
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic        load,
    output logic [7:0]  SEG,
    output logic [7:0]  AN,
    output logic        frame_done
);
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      pend_d, disp_d;
    logic [7:0]       pend_dp, disp_dp;
    logic             pend_v, tick, blank;
    logic [3:0]       nib;
    logic [6:0]       hex;

    assign tick       = cnt == CNT_W'(SCAN_DIV - 1);
    assign frame_done = tick && idx == 3'd7;
    assign nib        = disp_d[{idx, 2'b00} +: 4];

    always_comb begin
        hex = 7'h7F;
        case (nib)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            4'hF: hex = 7'h0E;
            default: hex = 7'h7F;
        endcase
    end

`ifdef SEG_LZ_BLANK_EN
    logic [2:0] msn;
    // msn stays 0 for an all-zero value, so digit 0 is never blanked
    always_comb begin
        msn = 3'd0;
        for (int i = 1; i < 8; i++)
            if (disp_d[4*i +: 4] != 4'd0) msn = 3'(i);
    end
    assign blank = idx > msn;
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            cnt     <= '0;
            idx     <= 3'd0;
            pend_d  <= 32'd0;
            pend_dp <= 8'd0;
            pend_v  <= 1'b0;
            disp_d  <= 32'd0;
            disp_dp <= 8'd0;
            SEG     <= 8'hFF;
            AN      <= 8'hFF;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) idx <= idx + 3'd1;
            if (frame_done && pend_v) begin
                disp_d  <= pend_d;
                disp_dp <= pend_dp;
            end
            if (load) begin
                pend_d  <= data_in;
                pend_dp <= dp_in;
            end
            // a load in the commit cycle keeps the flag set for the next frame
            pend_v <= load || (pend_v && !frame_done);
            SEG    <= {~disp_dp[idx], blank ? 7'h7F : hex};
            AN     <= ~(8'b1 << idx);
        end
    end
endmodule
